// File: rtl/new_usb_pkg.sv
// Shared constants and types for the USB transmit unpacker.
package new_usb_pkg;

    localparam logic [15:0] CrcPoly     = 16'hA001;
    localparam logic [15:0] CrcInit     = 16'hFFFF;
    localparam logic [15:0] CrcResidual = 16'hB001;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC_LO,
        CRC_HI
    } tx_state_e;

endpackage

// File: rtl/new_usb_crc16.sv
// CRC-16/USB single-byte update, reflected polynomial, LSB first.
module new_usb_crc16
    import new_usb_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_c
);

    always_comb begin
        crc_c = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_c = crc_c[0] ? ((crc_c >> 1) ^ CrcPoly) : (crc_c >> 1);
        end
    end

endmodule

// File: rtl/new_usb_tx_unpacker.sv
// Splits DMA FIFO words into a byte stream for the USB packet transmitter
// and appends the inverted CRC-16 of the payload, low byte first.
module new_usb_tx_unpacker
    import new_usb_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned TFLenWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [TFLenWidth-1:0] num_bytes_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [DataWidth-1:0]  fifo_data_i,
    input  logic                  fifo_valid_i,
    output logic                  fifo_ready_o,
    output logic [7:0]            byte_o,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic                  byte_last_o,
    output logic                  busy_o
);

    localparam int unsigned Lanes    = DataWidth / 8;
    localparam int unsigned IdxWidth = (Lanes > 1) ? $clog2(Lanes) : 1;

    tx_state_e             state_q;
    logic [TFLenWidth-1:0] remaining_q;
    logic [DataWidth-1:0]  word_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [IdxWidth-1:0]   idx_inc;
    logic [15:0]           crc_q;
    logic [15:0]           crc_upd;
    logic                  byte_hs;
    logic                  fifo_hs;
    logic                  job_hs;
    logic                  last_lane;
    logic                  last_byte;

    assign byte_hs   = byte_valid_o && byte_ready_i;
    assign fifo_hs   = fifo_valid_i && fifo_ready_o;
    assign job_hs    = job_valid_i && job_ready_o;
    assign idx_inc   = idx_q + IdxWidth'(1);
    assign last_lane = (idx_q == IdxWidth'(Lanes - 1));
    assign last_byte = (remaining_q == TFLenWidth'(1));

    // The byte on the wire is the one folded into the CRC when it is accepted.
    new_usb_crc16 u_crc (
        .crc_i  (crc_q),
        .data_i (byte_o),
        .crc_c  (crc_upd)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            crc_q        <= CrcInit;
            job_ready_o  <= 1'b0;
            fifo_ready_o <= 1'b0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            byte_last_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    job_ready_o <= 1'b1;
                    if (job_hs) begin
                        job_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        remaining_q <= num_bytes_i;
                        crc_q       <= CrcInit;
                        idx_q       <= '0;
                        if (num_bytes_i != '0) begin
                            state_q      <= DATA;
                            fifo_ready_o <= 1'b1;
                        end else begin
                            state_q      <= CRC_LO;
                            byte_o       <= ~CrcInit[7:0];
                            byte_valid_o <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    // byte_valid_o doubles as the word-held flag while in DATA.
                    if (fifo_hs) begin
                        word_q       <= fifo_data_i;
                        idx_q        <= '0;
                        fifo_ready_o <= 1'b0;
                        byte_o       <= fifo_data_i[7:0];
                        byte_valid_o <= 1'b1;
                    end else if (byte_hs) begin
                        crc_q       <= crc_upd;
                        remaining_q <= remaining_q - TFLenWidth'(1);
                        idx_q       <= idx_inc;
                        if (last_byte) begin
                            state_q <= CRC_LO;
                            byte_o  <= ~crc_upd[7:0];
                        end else if (last_lane) begin
                            byte_valid_o <= 1'b0;
                            fifo_ready_o <= 1'b1;
                        end else begin
                            byte_o <= 8'(word_q >> {idx_inc, 3'b000});
                        end
                    end
                end
                CRC_LO: begin
                    if (byte_hs) begin
                        state_q     <= CRC_HI;
                        byte_o      <= ~crc_q[15:8];
                        byte_last_o <= 1'b1;
                    end
                end
                CRC_HI: begin
                    if (byte_hs) begin
                        state_q      <= IDLE;
                        byte_o       <= '0;
                        byte_valid_o <= 1'b0;
                        byte_last_o  <= 1'b0;
                        busy_o       <= 1'b0;
                        job_ready_o  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/new_usb_tx_unpacker.md
NEW_USB_TX_UNPACKER -- requirements
Module: new_usb_tx_unpacker

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of the DMA FIFO word (multiple of 8).
REQ-002 SHALL have parameter TFLenWidth, default 8, width of the per-packet byte count.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port num_bytes_i, input, TFLenWidth, payload byte count of the packet job.
REQ-006 SHALL have ports job_valid_i / job_ready_o, input/output, 1 each, job handshake.
REQ-007 SHALL have port fifo_data_i, input, DataWidth, little-endian payload word from the DMA FIFO interface.
REQ-008 SHALL have ports fifo_valid_i / fifo_ready_o, input/output, 1 each, word handshake.
REQ-009 SHALL have port byte_o, output, 8, serial byte to the USB packet transmitter.
REQ-010 SHALL have ports byte_valid_o / byte_ready_i, output/input, 1 each, byte handshake.
REQ-011 SHALL have port byte_last_o, output, 1, marks the final byte (CRC high byte) of the packet.
REQ-012 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, DATA, CRC_LO, CRC_HI.
REQ-014 IDLE: job_ready_o=1; on job handshake latch num_bytes_i into remaining counter, set CRC register to 16'hFFFF, go DATA if num_bytes_i!=0, else CRC_LO.
REQ-015 DATA: hold one word register plus byte-lane index; fifo_ready_o=1 only when word register is empty and state is DATA.
REQ-016 DATA: byte_o = lane [8*idx +: 8] of held word; byte_valid_o=1 while word held.
REQ-017 On byte handshake: update CRC with byte, decrement remaining, increment idx; word register frees when idx wraps past DataWidth/8-1 or remaining reaches 0.
REQ-018 When remaining reaches 0, unused lanes of the last word SHALL be discarded and state goes CRC_LO next cycle.
REQ-019 Word refill SHALL be registered: one bubble cycle on byte_valid_o between words is permitted, no more.
REQ-020 CRC: CRC-16/USB (poly 0x8005 reflected = 0xA001, init 0xFFFF, LSB-first, output XOR 0xFFFF).
REQ-021 CRC_LO: byte_o = ~crc[7:0], byte_valid_o=1; on handshake go CRC_HI.
REQ-022 CRC_HI: byte_o = ~crc[15:8], byte_valid_o=1, byte_last_o=1; on handshake go IDLE.
REQ-023 byte_last_o SHALL be 0 in all other states; byte_o and byte_valid_o stable while byte_ready_i=0.
REQ-024 Zero-length job SHALL consume no FIFO word and emit exactly 0x00, 0x00 (last on second).
REQ-025 job_ready_o SHALL be 0 outside IDLE; a new job is accepted the cycle after CRC_HI handshake at earliest.
REQ-026 fifo_valid_i in IDLE/CRC states SHALL be ignored (not consumed).
REQ-027 Max payload 2**TFLenWidth-1 bytes; counter SHALL not wrap.

Reset
REQ-028 On rst_ni low, asynchronously: state IDLE, counters 0, word register empty, CRC 16'hFFFF.
REQ-029 Reset values: job_ready_o=0 during reset, 1 after; fifo_ready_o=0, byte_valid_o=0, byte_last_o=0, byte_o=0, busy_o=0.
REQ-030 Reset mid-packet SHALL abort the packet with no further bytes emitted.

Structure
REQ-031 Package new_usb_pkg SHALL hold CRC16 poly, init and residual constants and the state enum type.
REQ-032 CRC byte update SHALL be sub-module new_usb_crc16 (combinational, 16-bit crc in, 8-bit data in, 16-bit crc out).

Verification
REQ-033 Job 9, words 0x34333231, 0x38373635, 0x00000039 -> bytes 31..39, C8, B4; last on B4; 3 words consumed.
REQ-034 Job 0 -> bytes 00, 00 with last on second; fifo_ready_o never asserted.
REQ-035 Job 4, word 0x03020100, byte_ready_i toggled randomly -> 00,01,02,03 in order, outputs stable when stalled, then two CRC bytes matching golden model.
REQ-036 Job 255, 64 words of incrementing bytes, fifo_valid_i with random gaps -> 255 bytes in order, 64 words consumed, correct CRC.
REQ-037 Assert rst_ni low mid-DATA of job 9 -> next cycle byte_valid_o=0, busy_o=0; fresh job 9 after reset yields C8, B4.
REQ-038 Back-to-back jobs 1 then 2 with job_valid_i held high -> second job accepted only after first CRC_HI handshake; both packets correct.
